// File: rtl/axi_csr_bridge_pkg.sv
// rtl/axi_csr_bridge_pkg.sv - shared types and constants for the AXI-to-CSR bridge
package axi_csr_bridge_pkg;

  localparam int CsrWordBytes = 4;
  localparam int CsrAddrW     = 16;
  localparam int CsrDataW     = 32;
  localparam int AxiIdW       = 4;

  localparam logic [1:0] AXI_OKAY       = 2'b00;
  localparam logic [1:0] AXI_SLVERR     = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic                valid;
    logic                rd_or_wr;
    logic [CsrAddrW-1:0] addr;
    logic [CsrDataW-1:0] data_in;
  } s_csr_req_t;

  typedef struct packed {
    logic                ready;
    logic                error;
    logic [CsrDataW-1:0] data_out;
  } s_csr_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_DATA
  } csr_br_st_t;

endpackage

// File: rtl/axi_csr_bridge_if.sv
// rtl/axi_csr_bridge_if.sv - AXI4 AW/W/B/AR/R channel bundle seen by the CSR bridge
interface axi_csr_bridge_if;
  import axi_csr_bridge_pkg::*;

  logic                awvalid;
  logic                awready;
  logic [CsrAddrW-1:0] awaddr;
  logic [AxiIdW-1:0]   awid;
  logic [7:0]          awlen;

  logic                wvalid;
  logic                wready;
  logic [CsrDataW-1:0] wdata;
  logic [3:0]          wstrb;
  logic                wlast;

  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic [AxiIdW-1:0]   bid;

  logic                arvalid;
  logic                arready;
  logic [CsrAddrW-1:0] araddr;
  logic [AxiIdW-1:0]   arid;
  logic [7:0]          arlen;
  logic [1:0]          arburst;

  logic                rvalid;
  logic                rready;
  logic [CsrDataW-1:0] rdata;
  logic [1:0]          rresp;
  logic [AxiIdW-1:0]   rid;
  logic                rlast;

  modport slave (
    input  awvalid, awaddr, awid, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rid, rlast
  );

  modport master (
    output awvalid, awaddr, awid, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rid, rlast
  );

endinterface

// File: rtl/axi_csr_bridge.sv
// rtl/axi_csr_bridge.sv - AXI4 slave turning AW/W/AR bursts into single-cycle CSR accesses.
// Define CSR_BRIDGE_STRB_CHK_EN to reject partial-strobe writes with SLVERR.
module axi_csr_bridge
  import axi_csr_bridge_pkg::*;
#(
  parameter int MAX_RD_BEATS = 16
) (
  input  logic            clk_axi,
  input  logic            arst_axi,
  axi_csr_bridge_if.slave axi,
  output s_csr_req_t      csr_req_o,
  input  s_csr_resp_t     csr_resp_i,
  output logic            busy_o
);

  csr_br_st_t          r_state;
  csr_br_st_t          w_next;

  logic                r_rr_last_rd;
  logic [CsrAddrW-1:0] r_addr;
  logic [AxiIdW-1:0]   r_id;
  logic [7:0]          r_len;
  logic [7:0]          r_beat;
  logic                r_bad;
  logic [CsrDataW-1:0] r_wdata;
  logic [CsrDataW-1:0] r_rdata;
  logic [1:0]          r_bresp;
  logic [1:0]          r_rresp;

  logic                w_grant_wr;
  logic                w_grant_rd;
  logic                w_aw_bad;
  logic                w_ar_bad;
  logic                w_strb_bad;
  logic                w_w_last;
  logic                w_rlast;
  logic [CsrAddrW-1:0] w_beat_addr;

  // With both sides requesting, the side that did not win last time goes first.
  assign w_grant_wr = axi.awvalid & (~axi.arvalid | r_rr_last_rd);
  assign w_grant_rd = axi.arvalid & ~w_grant_wr;

  assign w_aw_bad = (axi.awlen != 8'd0) | (axi.awaddr[1:0] != 2'b00);
  assign w_ar_bad = ((int'(axi.arlen) + 1) > MAX_RD_BEATS)
                  | (axi.arburst != AXI_BURST_INCR)
                  | (axi.araddr[1:0] != 2'b00);

`ifdef CSR_BRIDGE_STRB_CHK_EN
  assign w_strb_bad = (axi.wstrb != 4'hF);
`else
  assign w_strb_bad = 1'b0;
`endif

  assign w_w_last    = axi.wvalid & axi.wlast;
  assign w_rlast     = (r_beat == r_len);
  assign w_beat_addr = r_addr + {6'd0, r_beat, 2'b00};

  assign axi.bresp = r_bresp;
  assign axi.bid   = r_id;
  assign axi.rdata = r_rdata;
  assign axi.rresp = r_rresp;
  assign axi.rid   = r_id;
  assign axi.rlast = (r_state == RD_DATA) & w_rlast;
  assign busy_o    = (r_state != IDLE);

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    axi.awready   = 1'b0;
    axi.wready    = 1'b0;
    axi.bvalid    = 1'b0;
    axi.arready   = 1'b0;
    axi.rvalid    = 1'b0;
    csr_req_o     = '0;
    case (r_state)
      IDLE: begin
        axi.awready = w_grant_wr;
        axi.arready = w_grant_rd;
        if (w_grant_wr) begin
          w_next = WR_DATA;
        end else if (w_grant_rd) begin
          w_next = w_ar_bad ? RD_DATA : RD_REQ;
        end
      end
      WR_DATA: begin
        axi.wready = 1'b1;
        if (w_w_last) begin
          w_next = (r_bad | w_strb_bad) ? WR_RESP : WR_REQ;
        end
      end
      WR_REQ: begin
        csr_req_o.valid    = 1'b1;
        csr_req_o.rd_or_wr = 1'b1;
        csr_req_o.addr     = r_addr;
        csr_req_o.data_in  = r_wdata;
        if (csr_resp_i.ready) begin
          w_next = WR_RESP;
        end
      end
      WR_RESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) begin
          w_next = IDLE;
        end
      end
      RD_REQ: begin
        csr_req_o.valid    = 1'b1;
        csr_req_o.rd_or_wr = 1'b0;
        csr_req_o.addr     = w_beat_addr;
        if (csr_resp_i.ready) begin
          w_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_next = RD_DATA;
      end
      RD_DATA: begin
        axi.rvalid = 1'b1;
        if (axi.rready) begin
          if (w_rlast) begin
            w_next = IDLE;
          end else begin
            w_next = r_bad ? RD_DATA : RD_REQ;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      r_rr_last_rd <= 1'b1;
      r_addr       <= '0;
      r_id         <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_bad        <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_bresp      <= AXI_OKAY;
      r_rresp      <= AXI_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            r_rr_last_rd <= 1'b0;
            r_addr       <= axi.awaddr;
            r_id         <= axi.awid;
            r_len        <= axi.awlen;
            r_bad        <= w_aw_bad;
          end else if (w_grant_rd) begin
            r_rr_last_rd <= 1'b1;
            r_addr       <= axi.araddr;
            r_id         <= axi.arid;
            r_len        <= axi.arlen;
            r_beat       <= '0;
            r_bad        <= w_ar_bad;
            r_rdata      <= '0;
            r_rresp      <= w_ar_bad ? AXI_SLVERR : AXI_OKAY;
          end
        end
        WR_DATA: begin
          if (w_w_last) begin
            r_wdata <= axi.wdata;
            if (r_bad | w_strb_bad) begin
              r_bresp <= AXI_SLVERR;
            end
          end
        end
        WR_REQ: begin
          if (csr_resp_i.ready) begin
            r_bresp <= csr_resp_i.error ? AXI_SLVERR : AXI_OKAY;
          end
        end
        RD_WAIT: begin
          // The CSR block registers read data, so it is valid one cycle after the request.
          r_rdata <= csr_resp_i.data_out;
          r_rresp <= csr_resp_i.error ? AXI_SLVERR : AXI_OKAY;
        end
        RD_DATA: begin
          if (axi.rready) begin
            r_beat <= r_beat + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_csr_bridge.sv
// tb/tb_axi_csr_bridge.sv - directed self-checking bench for axi_csr_bridge
`timescale 1ns/1ps
module tb_axi_csr_bridge;
  import axi_csr_bridge_pkg::*;

  localparam logic [15:0] RAVENOC_VERSION = 16'h1000;
  localparam logic [15:0] IRQ_RD_STATUS   = 16'h1010;
  localparam logic [15:0] SCRATCH         = 16'h1020;
  localparam logic [15:0] IRQ_RD_MASK     = 16'h1030;
  localparam int          TMO             = 64;

  logic        clk_axi  = 1'b0;
  logic        arst_axi = 1'b1;
  s_csr_req_t  csr_req;
  s_csr_resp_t csr_resp;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk_axi = ~clk_axi;

  axi_csr_bridge_if axi ();

  axi_csr_bridge #(.MAX_RD_BEATS(16)) dut (
    .clk_axi    (clk_axi),
    .arst_axi   (arst_axi),
    .axi        (axi),
    .csr_req_o  (csr_req),
    .csr_resp_i (csr_resp),
    .busy_o     (busy)
  );

  // CSR block model: writes to the version register fault, reads answer one cycle later.
  logic [31:0]   mem [64];
  bit            mem_ready = 1'b0;
  logic [31:0]   rd_data_q = '0;
  int            n_req = 0;
  int            n_wr  = 0;
  int            cyc   = 0;
  int            last_req_cyc = 0;
  logic [31:0]   last_wr_data = '0;
  logic [15:0]   rd_addrs [$];

  assign csr_resp.ready    = 1'b1;
  assign csr_resp.data_out = rd_data_q;
  assign csr_resp.error    = csr_req.valid & csr_req.rd_or_wr & (csr_req.addr == RAVENOC_VERSION);

  always @(posedge clk_axi) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC5A0_0000 + i;
      mem_ready <= 1'b1;
    end else if (csr_req.valid && csr_req.rd_or_wr && !csr_resp.error) begin
      mem[csr_req.addr[7:2]] <= csr_req.data_in;
    end
    if (csr_req.valid && !csr_req.rd_or_wr) rd_data_q <= mem[csr_req.addr[7:2]];
  end

  always @(posedge clk_axi) begin
    if (csr_req.valid) begin
      n_req = n_req + 1;
      last_req_cyc = cyc;
      if (csr_req.rd_or_wr) begin
        n_wr = n_wr + 1;
        last_wr_data = csr_req.data_in;
      end else begin
        rd_addrs.push_back(csr_req.addr);
      end
    end
    cyc = cyc + 1;
  end

  task automatic send_aw(input logic [15:0] a, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    axi.awaddr = a; axi.awid = id; axi.awlen = len; axi.awvalid = 1'b1;
    #1;
    while (!axi.awready && n < TMO) begin @(negedge clk_axi); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL aw_timeout awready=%0b required=1", axi.awready); end
    @(negedge clk_axi);
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input int beats);
    for (int b = 0; b < beats; b++) begin
      int n = 0;
      axi.wdata = d; axi.wstrb = strb; axi.wlast = (b == beats - 1); axi.wvalid = 1'b1;
      #1;
      while (!axi.wready && n < TMO) begin @(negedge clk_axi); #1; n++; end
      if (n >= TMO) begin checks++; failures++; $display("FAIL w_timeout wready=%0b required=1", axi.wready); end
      @(negedge clk_axi);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    axi.bready = 1'b1;
    #1;
    while (!axi.bvalid && n < TMO) begin @(negedge clk_axi); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL b_timeout bvalid=%0b required=1", axi.bvalid); end
    resp = axi.bresp; id = axi.bid;
    @(negedge clk_axi);
    axi.bready = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    axi.araddr = a; axi.arid = id; axi.arlen = len; axi.arburst = burst; axi.arvalid = 1'b1;
    #1;
    while (!axi.arready && n < TMO) begin @(negedge clk_axi); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL ar_timeout arready=%0b required=1", axi.arready); end
    @(negedge clk_axi);
    axi.arvalid = 1'b0;
  endtask

  task automatic recv_r(output logic [31:0] d, output logic [1:0] resp, output logic last, output logic [3:0] id);
    int n = 0;
    axi.rready = 1'b1;
    #1;
    while (!axi.rvalid && n < TMO) begin @(negedge clk_axi); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL r_timeout rvalid=%0b required=1", axi.rvalid); end
    d = axi.rdata; resp = axi.rresp; last = axi.rlast; id = axi.rid;
    @(negedge clk_axi);
    axi.rready = 1'b0;
  endtask

  task automatic drain_r(input int expect_beats, output int beats, output int slverr, output int nonzero, output int last_pos);
    int n = 0;
    beats = 0; slverr = 0; nonzero = 0; last_pos = -1;
    axi.rready = 1'b1;
    while (beats < expect_beats && n < 8 * TMO) begin
      #1;
      if (axi.rvalid) begin
        if (axi.rresp == AXI_SLVERR) slverr++;
        if (axi.rdata != 32'h0) nonzero++;
        if (axi.rlast) last_pos = beats;
        beats++;
      end
      @(negedge clk_axi);
      n++;
    end
    axi.rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_axi);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) begin failures++; $display("FAIL reset_valids bvalid=%0b rvalid=%0b exp=0", axi.bvalid, axi.rvalid); end
    checks++; if (axi.bresp !== AXI_OKAY || axi.rresp !== AXI_OKAY) begin failures++; $display("FAIL reset_resp bresp=%0h rresp=%0h exp=0", axi.bresp, axi.rresp); end
    checks++; if (axi.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%08h exp=0", axi.rdata); end
    checks++; if (csr_req !== s_csr_req_t'('0)) begin failures++; $display("FAIL reset_csr_req got=%0h exp=0", csr_req); end
    arst_axi = 1'b0;
    @(negedge clk_axi);
    checks++; if (axi.awready !== 1'b0 || axi.arready !== 1'b0 || axi.wready !== 1'b0) begin failures++; $display("FAIL reset_readys aw=%0b ar=%0b w=%0b exp=0", axi.awready, axi.arready, axi.wready); end
  endtask

  task automatic test_write_ok();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int wr0;
    wr0 = n_wr;
    send_aw(IRQ_RD_MASK, 4'd1, 8'd0);
    send_w(32'h0000_00A5, 4'hF, 1);
    recv_b(resp, id);
    checks++; if (resp !== AXI_OKAY) begin failures++; $display("FAIL wr_ok_bresp got=%0h exp=0", resp); end
    checks++; if (id !== 4'd1) begin failures++; $display("FAIL wr_ok_bid got=%0d exp=1", id); end
    checks++; if (n_wr - wr0 != 1) begin failures++; $display("FAIL wr_ok_req_cycles got=%0d exp=1", n_wr - wr0); end
    checks++; if (last_wr_data !== 32'h0000_00A5) begin failures++; $display("FAIL wr_ok_data got=%08h exp=000000a5", last_wr_data); end
    send_ar(IRQ_RD_MASK, 4'd2, 8'd0, AXI_BURST_INCR);
    recv_r(d, resp, last, id);
    checks++; if (d !== 32'h0000_00A5 || resp !== AXI_OKAY) begin failures++; $display("FAIL rd_back got=%08h/%0h exp=000000a5/0", d, resp); end
    checks++; if (last !== 1'b1 || id !== 4'd2) begin failures++; $display("FAIL rd_back_last_id got=%0b/%0d exp=1/2", last, id); end
  endtask

  task automatic test_write_err();
    logic [1:0] resp; logic [3:0] id; int req0;
    send_aw(RAVENOC_VERSION, 4'd3, 8'd0);
    send_w(32'hDEAD_BEEF, 4'hF, 1);
    recv_b(resp, id);
    checks++; if (resp !== AXI_SLVERR) begin failures++; $display("FAIL wr_err_bresp got=%0h exp=2", resp); end
    checks++; if (id !== 4'd3) begin failures++; $display("FAIL wr_err_bid got=%0d exp=3", id); end
    req0 = n_req;
    send_aw(16'h1022, 4'd5, 8'd0);
    send_w(32'h0BAD_0BAD, 4'hF, 1);
    recv_b(resp, id);
    checks++; if (resp !== AXI_SLVERR || n_req != req0) begin failures++; $display("FAIL wr_unaligned got=%0h reqs=%0d exp=2 reqs=0", resp, n_req - req0); end
    send_aw(SCRATCH, 4'd6, 8'd2);
    send_w(32'h0BAD_0BAD, 4'hF, 3);
    recv_b(resp, id);
    checks++; if (resp !== AXI_SLVERR || n_req != req0 || id !== 4'd6) begin failures++; $display("FAIL wr_burst got=%0h reqs=%0d id=%0d exp=2 reqs=0 id=6", resp, n_req - req0, id); end
  endtask

  task automatic test_incr_read();
    logic [31:0] exp_d [4];
    logic [31:0] d0; logic l0; int n;
    exp_d = '{32'hC5A0_0004, 32'hC5A0_0005, 32'hC5A0_0006, 32'hC5A0_0007};
    rd_addrs.delete();
    send_ar(IRQ_RD_STATUS, 4'd7, 8'd3, AXI_BURST_INCR);
    for (int b = 0; b < 4; b++) begin
      n = 0;
      #1;
      while (!axi.rvalid && n < TMO) begin @(negedge clk_axi); #1; n++; end
      if (n >= TMO) begin checks++; failures++; $display("FAIL incr_timeout beat=%0d rvalid=0 exp=1", b); end
      checks++; if (cyc - last_req_cyc != 2) begin failures++; $display("FAIL incr_latency beat=%0d got=%0d exp=2", b, cyc - last_req_cyc); end
      checks++; if (axi.rdata !== exp_d[b] || axi.rresp !== AXI_OKAY || axi.rid !== 4'd7) begin failures++; $display("FAIL incr_data beat=%0d got=%08h/%0h/%0d exp=%08h/0/7", b, axi.rdata, axi.rresp, axi.rid, exp_d[b]); end
      checks++; if (axi.rlast !== (b == 3)) begin failures++; $display("FAIL incr_rlast beat=%0d got=%0b exp=%0b", b, axi.rlast, (b == 3)); end
      d0 = axi.rdata; l0 = axi.rlast;
      @(negedge clk_axi); #1;
      checks++; if (axi.rvalid !== 1'b1 || axi.rdata !== d0 || axi.rlast !== l0) begin failures++; $display("FAIL incr_stall beat=%0d got=%0b/%08h exp=1/%08h", b, axi.rvalid, axi.rdata, d0); end
      axi.rready = 1'b1;
      @(negedge clk_axi);
      axi.rready = 1'b0;
    end
    checks++; if (rd_addrs.size() != 4) begin failures++; $display("FAIL incr_req_count got=%0d exp=4", rd_addrs.size()); end
    else begin
      for (int b = 0; b < 4; b++) begin
        checks++; if (rd_addrs[b] !== IRQ_RD_STATUS + 16'(4 * b)) begin failures++; $display("FAIL incr_addr beat=%0d got=%04h exp=%04h", b, rd_addrs[b], IRQ_RD_STATUS + 16'(4 * b)); end
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL incr_busy_after got=%0b exp=0", busy); end
  endtask

  task automatic test_oversize_read();
    int beats, slv, nz, lp, req0;
    req0 = n_req;
    send_ar(IRQ_RD_STATUS, 4'd4, 8'd16, AXI_BURST_INCR);
    drain_r(17, beats, slv, nz, lp);
    checks++; if (beats != 17 || slv != 17 || nz != 0) begin failures++; $display("FAIL over_beats got=%0d slverr=%0d nonzero=%0d exp=17/17/0", beats, slv, nz); end
    checks++; if (lp != 16) begin failures++; $display("FAIL over_rlast_pos got=%0d exp=16", lp); end
    checks++; if (n_req != req0 || busy !== 1'b0) begin failures++; $display("FAIL over_no_req reqs=%0d busy=%0b exp=0/0", n_req - req0, busy); end
    send_ar(IRQ_RD_STATUS, 4'd4, 8'd0, 2'b00);
    drain_r(1, beats, slv, nz, lp);
    checks++; if (beats != 1 || slv != 1 || n_req != req0) begin failures++; $display("FAIL fixed_burst beats=%0d slverr=%0d reqs=%0d exp=1/1/0", beats, slv, n_req - req0); end
    send_ar(IRQ_RD_STATUS, 4'd4, 8'd15, AXI_BURST_INCR);
    drain_r(16, beats, slv, nz, lp);
    checks++; if (beats != 16 || slv != 0 || n_req - req0 != 16 || lp != 15) begin failures++; $display("FAIL max_burst beats=%0d slverr=%0d reqs=%0d last=%0d exp=16/0/16/15", beats, slv, n_req - req0, lp); end
  endtask

  task automatic test_rr_arb();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int n;
    arst_axi = 1'b1;
    @(negedge clk_axi);
    arst_axi = 1'b0;
    @(negedge clk_axi);
    axi.awaddr = SCRATCH; axi.awid = 4'd8; axi.awlen = 8'd0;
    axi.araddr = IRQ_RD_MASK; axi.arid = 4'd9; axi.arlen = 8'd0; axi.arburst = AXI_BURST_INCR;
    axi.awvalid = 1'b1; axi.arvalid = 1'b1;
    #1;
    checks++; if (axi.awready !== 1'b1 || axi.arready !== 1'b0) begin failures++; $display("FAIL rr_first aw=%0b ar=%0b exp=1/0", axi.awready, axi.arready); end
    @(negedge clk_axi);
    axi.awvalid = 1'b0;
    send_w(32'h0000_1111, 4'hF, 1);
    axi.bready = 1'b1;
    n = 0; #1;
    while (!axi.bvalid && n < TMO) begin @(negedge clk_axi); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL rr_b_timeout bvalid=0 exp=1"); end
    axi.awid = 4'd10; axi.awvalid = 1'b1;
    @(negedge clk_axi);
    axi.bready = 1'b0;
    #1;
    checks++; if (axi.arready !== 1'b1 || axi.awready !== 1'b0) begin failures++; $display("FAIL rr_second aw=%0b ar=%0b exp=0/1", axi.awready, axi.arready); end
    @(negedge clk_axi);
    axi.arvalid = 1'b0;
    recv_r(d, resp, last, id);
    checks++; if (d !== 32'h0000_00A5 || id !== 4'd9) begin failures++; $display("FAIL rr_read got=%08h id=%0d exp=000000a5 id=9", d, id); end
    n = 0; #1;
    while (!axi.awready && n < TMO) begin @(negedge clk_axi); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL rr_aw_timeout awready=0 exp=1"); end
    @(negedge clk_axi);
    axi.awvalid = 1'b0;
    send_w(32'h0000_2222, 4'hF, 1);
    recv_b(resp, id);
    checks++; if (resp !== AXI_OKAY || id !== 4'd10) begin failures++; $display("FAIL rr_third_b got=%0h id=%0d exp=0 id=10", resp, id); end
    checks++; if (mem[8] !== 32'h0000_2222) begin failures++; $display("FAIL rr_scratch got=%08h exp=00002222", mem[8]); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int n;
    send_ar(IRQ_RD_MASK, 4'd11, 8'd0, AXI_BURST_INCR);
    n = 0; #1;
    while (!axi.rvalid && n < TMO) begin @(negedge clk_axi); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL mid_timeout rvalid=0 exp=1"); end
    arst_axi = 1'b1;
    @(negedge clk_axi);
    checks++; if (axi.rvalid !== 1'b0 || axi.bvalid !== 1'b0 || csr_req.valid !== 1'b0) begin failures++; $display("FAIL mid_valids r=%0b b=%0b req=%0b exp=0", axi.rvalid, axi.bvalid, csr_req.valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    arst_axi = 1'b0;
    @(negedge clk_axi);
    send_ar(IRQ_RD_MASK, 4'd12, 8'd0, AXI_BURST_INCR);
    recv_r(d, resp, last, id);
    checks++; if (d !== 32'h0000_00A5 || resp !== AXI_OKAY || id !== 4'd12 || last !== 1'b1) begin failures++; $display("FAIL mid_next_read got=%08h/%0h/%0d/%0b exp=000000a5/0/12/1", d, resp, id, last); end
  endtask

  task automatic test_strb();
    logic [1:0] resp; logic [3:0] id; logic [1:0] exp_resp; int exp_wr; int wr0;
`ifdef CSR_BRIDGE_STRB_CHK_EN
    exp_resp = AXI_SLVERR; exp_wr = 0;
`else
    exp_resp = AXI_OKAY; exp_wr = 1;
`endif
    wr0 = n_wr;
    send_aw(SCRATCH, 4'd13, 8'd0);
    send_w(32'h1234_5678, 4'h3, 1);
    recv_b(resp, id);
    checks++; if (resp !== exp_resp) begin failures++; $display("FAIL strb_bresp got=%0h exp=%0h", resp, exp_resp); end
    checks++; if (n_wr - wr0 != exp_wr) begin failures++; $display("FAIL strb_req got=%0d exp=%0d", n_wr - wr0, exp_wr); end
  endtask

  initial begin
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.awid = '0; axi.awlen = '0;
    axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.bready = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arid = '0; axi.arlen = '0; axi.arburst = AXI_BURST_INCR;
    axi.rready = 1'b0;
    test_reset();
    test_write_ok();
    test_write_err();
    test_incr_read();
    test_oversize_read();
    test_rr_arb();
    test_reset_mid();
    test_strb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
